// File: rtl/classificador_pkg.sv
// classificador_pkg
// Shared constants and FSM state encoding for the digit classifier.
//   NUM_DIGITOS : number of digit templates scored per run
//   TAM_GRADE   : side of the square difference grid
//   PIXEL_W     : width of one difference pixel
//   SCORE_W     : width of the accumulated score
//   LINHA_W     : width of one row sum (11 * 255 = 2805 fits in 12 bits)
package classificador_pkg;

    localparam int NUM_DIGITOS = 10;
    localparam int TAM_GRADE   = 11;
    localparam int PIXEL_W     = 8;
    localparam int SCORE_W     = 16;
    localparam int LINHA_W     = 12;

    typedef enum logic [1:0] {
        IDLE,
        SOMA,
        COMPARA,
        FIM
    } estado_t;

endpackage

// File: rtl/classificador_digito_somador_linha.sv
// somador_linha
// Combinational sum of one grid row (11 unsigned 8-bit pixels) into 12 bits.
// Ports:
//   linha : the 11 pixels of the row being summed
//   soma  : row sum, max 2805
module somador_linha
    import classificador_pkg::*;
(
    input  logic [TAM_GRADE-1:0][PIXEL_W-1:0] linha,
    output logic [LINHA_W-1:0]                soma
);

    always_comb begin
        soma = '0;
        for (int i = 0; i < TAM_GRADE; i++) begin
            soma = soma + LINHA_W'(linha[i]);
        end
    end

endmodule

// File: rtl/classificador_digito.sv
// classificador_digito
// Walks the ten digit templates, steering an external mux through digito_sel,
// sums each 11x11 difference array one row per cycle and reports the digit
// with the smallest score (ties keep the lower digit).
// Optional feature macro: CLASSIFICADOR_REJEITA_EN -- when defined, valido
// reports whether the best score is <= LIMIAR; otherwise valido is 1 after
// every run.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : request a run (sampled in IDLE only)
//   diff_pixel  : difference array of the digit selected by digito_sel
//   digito_sel  : digit currently being scored
//   busy        : run in progress
//   done        : one-cycle pulse when results update
//   digito      : best digit
//   pontuacao   : best score
//   valido      : result accepted
//
// state   | meaning
// IDLE    | waiting for start
// SOMA    | adding one row of the selected digit per cycle
// COMPARA | comparing the finished score against the best so far
// FIM     | results published, done high for this cycle
module classificador_digito
    import classificador_pkg::*;
#(
    parameter logic [SCORE_W-1:0] LIMIAR = 16'd12000
)(
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    input  logic [TAM_GRADE-1:0][TAM_GRADE-1:0][PIXEL_W-1:0] diff_pixel,
    output logic [3:0]                                       digito_sel,
    output logic                                             busy,
    output logic                                             done,
    output logic [3:0]                                       digito,
    output logic [SCORE_W-1:0]                               pontuacao,
    output logic                                             valido
);

    localparam logic [3:0] ULTIMA_LINHA  = 4'(TAM_GRADE - 1);
    localparam logic [3:0] ULTIMO_DIGITO = 4'(NUM_DIGITOS - 1);

    estado_t              estado;
    logic [3:0]           linha;
    logic [SCORE_W-1:0]   acc;
    logic [SCORE_W-1:0]   melhor_score;
    logic [3:0]           melhor_idx;

    logic [LINHA_W-1:0]   soma_linha;
    logic                 melhora;
    logic [SCORE_W-1:0]   score_final;
    logic [3:0]           idx_final;

    somador_linha u_somador_linha (
        .linha (diff_pixel[linha]),
        .soma  (soma_linha)
    );

    // Outputs are registered, so the last comparison's winner is computed
    // here and loaded on the COMPARA->FIM edge; that way results are already
    // visible in the FIM cycle together with done.
    always_comb begin
        melhora     = (acc < melhor_score);
        score_final = melhora ? acc : melhor_score;
        idx_final   = melhora ? digito_sel : melhor_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= IDLE;
            linha        <= '0;
            acc          <= '0;
            melhor_score <= '1;
            melhor_idx   <= '0;
            digito_sel   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            digito       <= '0;
            pontuacao    <= '1;
            valido       <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        estado       <= SOMA;
                        busy         <= 1'b1;
                        digito_sel   <= '0;
                        linha        <= '0;
                        acc          <= '0;
                        melhor_score <= '1;
                    end
                end
                SOMA: begin
                    // 121 * 255 = 30855 max, no overflow possible
                    acc <= acc + SCORE_W'(soma_linha);
                    if (linha == ULTIMA_LINHA) begin
                        estado <= COMPARA;
                    end else begin
                        linha <= linha + 4'd1;
                    end
                end
                COMPARA: begin
                    if (melhora) begin
                        melhor_score <= acc;
                        melhor_idx   <= digito_sel;
                    end
                    if (digito_sel == ULTIMO_DIGITO) begin
                        estado    <= FIM;
                        done      <= 1'b1;
                        digito    <= idx_final;
                        pontuacao <= score_final;
`ifdef CLASSIFICADOR_REJEITA_EN
                        valido    <= (score_final <= LIMIAR);
`else
                        valido    <= 1'b1;
`endif
                    end else begin
                        estado     <= SOMA;
                        digito_sel <= digito_sel + 4'd1;
                        acc        <= '0;
                        linha      <= '0;
                    end
                end
                FIM: begin
                    estado     <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    digito_sel <= '0;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule
